// File: rtl/clock_ctrl_pkg.sv
// Shared encodings, field limits and helpers for the timekeeping controller.
// ALARM_SNOOZE_EN adds the SNOOZED alarm state.
package clock_ctrl_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HRS_W  = 4;
  localparam int RING_W = 6;
`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W  = 4;
`endif

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [3:0] HRS_MAX = 4'd11;
  localparam logic [5:0] AL_STEP = 6'd10;
  // Alarm minutes at or above this value wrap to 0 on the next step.
  localparam logic [5:0] AL_WRAP = 6'd60 - AL_STEP;

  localparam int NUM_EV    = 6;
  localparam int EV_TICK   = 0;
  localparam int EV_SEC    = 1;
  localparam int EV_MIN    = 2;
  localparam int EV_HRS    = 3;
  localparam int EV_AL_ADJ = 4;
  localparam int EV_TOGGLE = 5;

  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_CARRY_MIN = 3'd1,
    SEQ_CARRY_HR  = 3'd2,
    SEQ_AL_CARRY  = 3'd3,
    SEQ_CHECK     = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    AL_OFF     = 2'd0,
    AL_ARMED   = 2'd1,
    AL_RINGING = 2'd2
`ifdef ALARM_SNOOZE_EN
    , AL_SNOOZED = 2'd3
`endif
  } alarm_state_t;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/event_pending_arbiter.sv
// Latches input pulses into pending flags and grants the highest-priority one
// while the sequencer is idle (bit 0 = highest priority).
module event_pending_arbiter
  import clock_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_EV-1:0] ev,
  input  logic              idle,
  input  logic [NUM_EV-1:0] clr,
  output logic [NUM_EV-1:0] grant
);

  logic [NUM_EV-1:0] pending;

  // A pulse arriving on the service edge re-sets its own flag.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr) | ev;
  end

  always_comb begin
    grant = '0;
    if (idle) begin
      for (int i = NUM_EV - 1; i >= 0; i--) begin
        if (pending[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/timekeeping_controller.sv
// Event sequencer for the clock's time/alarm registers and the alarm state machine.
// Optional feature: define ALARM_SNOOZE_EN for the snooze state.
module timekeeping_controller
  import clock_ctrl_pkg::*;
#(
  parameter int RING_SECS  = 30,
  parameter int SNOOZE_MIN = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sec_tick,
  input  logic             sec_adj,
  input  logic             min_adj,
  input  logic             hrs_adj,
  input  logic             al_adj,
  input  logic             al_toggle,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [HRS_W-1:0] hours,
  output logic [MIN_W-1:0] al_minutes,
  output logic [HRS_W-1:0] al_hours,
  output logic             al_on,
  output logic             alarm,
  output logic             busy
);

  if (RING_SECS < 1 || RING_SECS > 63) begin : g_bad_ring
    $error("RING_SECS must be in 1..63");
  end
  if (SNOOZE_MIN < 1 || SNOOZE_MIN > 15) begin : g_bad_snooze
    $error("SNOOZE_MIN must be in 1..15");
  end

  seq_state_t        seq, seq_next;
  alarm_state_t      al_st, al_next;
  logic [RING_W-1:0] ring_cnt, ring_next;
  logic [NUM_EV-1:0] grant;
  logic              match, tick_svc, tog_svc, rollover;

  event_pending_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .ev    ({al_toggle, al_adj, hrs_adj, min_adj, sec_adj, sec_tick}),
    .idle  (seq == SEQ_IDLE),
    .clr   (grant),
    .grant (grant)
  );

  assign tick_svc = grant[EV_TICK];
  assign tog_svc  = grant[EV_TOGGLE];
  assign rollover = tick_svc && (seconds == SEC_MAX);
  assign match    = (hours == al_hours) && (minutes == al_minutes) && (seconds == '0);

  always_comb begin
    seq_next = seq;
    case (seq)
      SEQ_IDLE: begin
        if (tick_svc)
          seq_next = rollover ? SEQ_CARRY_MIN : SEQ_CHECK;
        else if (grant[EV_SEC] || grant[EV_MIN] || grant[EV_HRS])
          seq_next = SEQ_CHECK;
        else if (grant[EV_AL_ADJ])
          seq_next = (al_minutes >= AL_WRAP) ? SEQ_AL_CARRY : SEQ_IDLE;
      end
      SEQ_CARRY_MIN: seq_next = (minutes == MIN_MAX) ? SEQ_CARRY_HR : SEQ_CHECK;
      SEQ_CARRY_HR:  seq_next = SEQ_CHECK;
      SEQ_AL_CARRY:  seq_next = SEQ_IDLE;
      SEQ_CHECK:     seq_next = SEQ_IDLE;
      default:       seq_next = SEQ_IDLE;
    endcase
  end

`ifdef ALARM_SNOOZE_EN
  logic [SNZ_W-1:0] snz_cnt, snz_next;
`endif

  always_comb begin
    al_next   = al_st;
    ring_next = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snz_next  = snz_cnt;
`endif
    case (al_st)
      AL_OFF: if (tog_svc) al_next = AL_ARMED;
      AL_ARMED: begin
        if (tog_svc) begin
          al_next = AL_OFF;
        end else if (seq == SEQ_CHECK && match) begin
          al_next   = AL_RINGING;
          ring_next = RING_W'(RING_SECS);
        end
      end
      AL_RINGING: begin
        if (tog_svc) begin
`ifdef ALARM_SNOOZE_EN
          al_next  = AL_SNOOZED;
          snz_next = SNZ_W'(SNOOZE_MIN);
`else
          al_next  = AL_OFF;
`endif
        end else if (tick_svc) begin
          ring_next = ring_cnt - 1'b1;
          if (ring_cnt <= 1) al_next = AL_ARMED;
        end
      end
`ifdef ALARM_SNOOZE_EN
      AL_SNOOZED: begin
        if (tog_svc) begin
          al_next = AL_OFF;
        end else if (rollover) begin
          snz_next = snz_cnt - 1'b1;
          if (snz_cnt <= 1) begin
            al_next   = AL_RINGING;
            ring_next = RING_W'(RING_SECS);
          end
        end
      end
`endif
      default: al_next = AL_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq      <= SEQ_IDLE;
      al_st    <= AL_OFF;
      ring_cnt <= '0;
      busy     <= 1'b0;
      al_on    <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      seq      <= seq_next;
      al_st    <= al_next;
      ring_cnt <= ring_next;
      busy     <= (seq_next != SEQ_IDLE);
      al_on    <= (al_next != AL_OFF);
      alarm    <= (al_next == AL_RINGING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk) begin
    if (reset) snz_cnt <= '0;
    else       snz_cnt <= snz_next;
  end
`endif

  // Field updates: primary step in IDLE, carries ripple one field per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      seconds    <= '0;
      minutes    <= '0;
      hours      <= '0;
      al_minutes <= '0;
      al_hours   <= '0;
    end else begin
      case (seq)
        SEQ_IDLE: begin
          if (tick_svc || grant[EV_SEC]) seconds <= wrap_inc(seconds, SEC_MAX);
          if (grant[EV_MIN]) minutes <= wrap_inc(minutes, MIN_MAX);
          if (grant[EV_HRS]) hours <= HRS_W'(wrap_inc({2'b00, hours}, {2'b00, HRS_MAX}));
          if (grant[EV_AL_ADJ])
            al_minutes <= (al_minutes >= AL_WRAP) ? '0 : al_minutes + AL_STEP;
        end
        SEQ_CARRY_MIN: minutes <= wrap_inc(minutes, MIN_MAX);
        SEQ_CARRY_HR:  hours <= HRS_W'(wrap_inc({2'b00, hours}, {2'b00, HRS_MAX}));
        SEQ_AL_CARRY:  al_hours <= HRS_W'(wrap_inc({2'b00, al_hours}, {2'b00, HRS_MAX}));
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timekeeping_controller.sv
// Directed and randomized bench for timekeeping_controller against a time-of-day model.
module tb_timekeeping_controller;

  localparam int RING = 30;
  localparam int SNZ  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 0, sec_adj = 0, min_adj = 0, hrs_adj = 0, al_adj = 0, al_toggle = 0;
  logic [5:0] seconds, minutes, al_minutes;
  logic [3:0] hours, al_hours;
  logic       al_on, alarm, busy;

  timekeeping_controller #(.RING_SECS(RING), .SNOOZE_MIN(SNZ)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .sec_adj(sec_adj), .min_adj(min_adj),
    .hrs_adj(hrs_adj), .al_adj(al_adj), .al_toggle(al_toggle), .seconds(seconds),
    .minutes(minutes), .hours(hours), .al_minutes(al_minutes), .al_hours(al_hours),
    .al_on(al_on), .alarm(alarm), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: seconds since 00:00:00 on a 12-hour face, alarm in 10-minute steps.
  int tod = 0, al10 = 0, ast = 0, ring_left = 0, snz_left = 0;

  task automatic m_reset();
    tod = 0; al10 = 0; ast = 0; ring_left = 0; snz_left = 0;
  endtask

  task automatic m_match();
    if (ast == 1 && tod == al10 * 600) begin
      ast = 2; ring_left = RING;
    end
  endtask

  task automatic m_event(input int k);
    int f;
    case (k)
      0: begin
        f = tod % 60;
        tod = (tod + 1) % 43200;
        if (ast == 2) begin
          ring_left--;
          if (ring_left == 0) ast = 1;
        end else if (ast == 3 && f == 59) begin
          snz_left--;
          if (snz_left == 0) begin ast = 2; ring_left = RING; end
        end
        m_match();
      end
      1: begin f = tod % 60;          tod = tod - f + (f + 1) % 60;               m_match(); end
      2: begin f = (tod / 60) % 60;   tod = tod - f * 60 + ((f + 1) % 60) * 60;   m_match(); end
      3: begin f = tod / 3600;        tod = tod - f * 3600 + ((f + 1) % 12) * 3600; m_match(); end
      4: al10 = (al10 + 1) % 72;
      default: begin
        if (ast == 0) ast = 1;
        else if (ast == 2) begin
`ifdef ALARM_SNOOZE_EN
          ast = 3; snz_left = SNZ;
`else
          ast = 0;
`endif
        end else ast = 0;
      end
    endcase
  endtask

  task automatic m_apply(input logic [5:0] m);
    for (int k = 0; k < 6; k++) if (m[k]) m_event(k);
  endtask

  task automatic set_in(input logic [5:0] m);
    {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, sec_tick} = m;
  endtask

  task automatic fire(input logic [5:0] m, input int settle);
    @(negedge clk); set_in(m);
    @(negedge clk); set_in(6'd0);
    m_apply(m);
    repeat (settle) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sec"},   32'(seconds),    32'(tod % 60));
    chk({tag, ".min"},   32'(minutes),    32'((tod / 60) % 60));
    chk({tag, ".hrs"},   32'(hours),      32'(tod / 3600));
    chk({tag, ".almin"}, 32'(al_minutes), 32'((al10 % 6) * 10));
    chk({tag, ".alhrs"}, 32'(al_hours),   32'(al10 / 6));
    chk({tag, ".alon"},  32'(al_on),      32'(ast != 0));
    chk({tag, ".alarm"}, 32'(alarm),      32'(ast == 2));
    chk({tag, ".busy"},  32'(busy),       32'd0);
  endtask

  task automatic goto_time(input int h, input int m, input int s);
    while (tod / 3600 != h)       fire(6'b001000, 3);
    while ((tod / 60) % 60 != m)  fire(6'b000100, 3);
    while (tod % 60 != s)         fire(6'b000010, 3);
  endtask

  initial begin
    logic [5:0] rm;
    m_reset();
    repeat (3) @(negedge clk);
    chk_all("reset");
    reset = 1'b0;

    for (int i = 0; i < 3; i++) fire(6'b000001, 10);
    chk("three_ticks", 32'(seconds), 32'd3);
    chk_all("ticks");

    goto_time(0, 59, 59);
    chk_all("preload");
    @(negedge clk); set_in(6'b000001);
    @(negedge clk); set_in(6'd0);
    chk("lat.flag_only", 32'(seconds), 32'd59);
    chk("lat.busy0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("carry.sec", 32'(seconds), 32'd0);
    chk("carry.min_pending", 32'(minutes), 32'd59);
    chk("carry.busy1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("carry.min", 32'(minutes), 32'd0);
    chk("carry.busy2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("carry.hrs", 32'(hours), 32'd1);
    chk("carry.busy3", 32'(busy), 32'd1);
    @(negedge clk);
    chk("carry.idle", 32'(busy), 32'd0);
    m_apply(6'b000001);
    chk_all("carry");

    goto_time(11, 59, 59);
    fire(6'b000001, 6);
    chk("wrap12.hrs", 32'(hours), 32'd0);
    chk("wrap12.min", 32'(minutes), 32'd0);
    chk("wrap12.sec", 32'(seconds), 32'd0);

    fire(6'b000101, 10);
    chk("collide.sec", 32'(seconds), 32'd1);
    chk("collide.min", 32'(minutes), 32'd1);
    chk_all("collide");

    @(negedge clk); set_in(6'b000011);
    @(negedge clk); set_in(6'b000010);
    @(negedge clk); set_in(6'd0);
    m_apply(6'b000011);
    repeat (10) @(negedge clk);
    chk_all("coalesce");

    @(negedge clk); set_in(6'b000010);
    @(negedge clk); set_in(6'b000010);
    @(negedge clk); set_in(6'd0);
    m_event(1); m_event(1);
    repeat (10) @(negedge clk);
    chk_all("reset_flag");

    for (int i = 1; i <= 7; i++) begin
      fire(6'b010000, 4);
      chk($sformatf("aladj%0d.min", i), 32'(al_minutes), 32'((i % 6) * 10));
      chk($sformatf("aladj%0d.hrs", i), 32'(al_hours), 32'(i / 6));
    end

    goto_time(1, 9, 59);
    fire(6'b100000, 4);
    chk("arm.alon", 32'(al_on), 32'd1);
    chk("arm.alarm", 32'(alarm), 32'd0);
    fire(6'b000001, 6);
    chk("ring.alarm", 32'(alarm), 32'd1);
    for (int i = 0; i < RING - 1; i++) fire(6'b000001, 6);
    chk("ring_last.alarm", 32'(alarm), 32'd1);
    fire(6'b000001, 6);
    chk("autostop.alarm", 32'(alarm), 32'd0);
    chk("autostop.alon", 32'(al_on), 32'd1);
    chk_all("autostop");

    goto_time(1, 59, 59);
    while (al10 != 12) fire(6'b010000, 4);
    fire(6'b000001, 6);
    chk("ring2.alarm", 32'(alarm), 32'd1);
    fire(6'b100000, 4);
`ifdef ALARM_SNOOZE_EN
    chk("snooze.alarm", 32'(alarm), 32'd0);
    chk("snooze.alon", 32'(al_on), 32'd1);
    for (int r = 0; r < SNZ; r++) begin
      while (tod % 60 != 59) fire(6'b000010, 3);
      chk($sformatf("snooze%0d.alarm", r), 32'(alarm), 32'd0);
      fire(6'b000001, 6);
    end
    chk("wake.alarm", 32'(alarm), 32'd1);
    chk_all("wake");
`else
    chk("stop.alarm", 32'(alarm), 32'd0);
    chk("stop.alon", 32'(al_on), 32'd0);
    fire(6'b100000, 4);
    for (int i = 0; i < 12; i++) fire(6'b001000, 4);
    chk("adjmatch.alarm", 32'(alarm), 32'd1);
    chk_all("adjmatch");
`endif

    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("rst.outs", {seconds, minutes, hours, al_minutes, al_hours, al_on, alarm, busy}, 32'd0);
    reset = 1'b0;
    m_reset();

    for (int i = 0; i < 60; i++) begin
      rm = 6'($urandom_range(0, 63));
      fire(rm, 30);
      chk_all($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
